// File: rtl/sp_ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM: combinational round-robin grant,
// one-cycle response routing, per-port read-data hold and a saturating conflict counter.
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn_i,

    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,

    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

    output logic [15:0]             conflict_cnt_o
);

    localparam logic [0:0] PRIO_P0 = 1'b0;
    localparam logic [0:0] PRIO_P1 = 1'b1;

    logic [0:0]            state_q, state_d;
    logic                  own_valid_q, own_valid_d;
    logic                  own_port_q, own_port_d;
    logic                  own_read_q, own_read_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic [15:0]           cnt_q, cnt_d;

    always_comb begin
        p0_gnt_o = p0_req_i & (~p1_req_i | (state_q == PRIO_P0));
        p1_gnt_o = p1_req_i & ~p0_gnt_o;
        ram_en_o = p0_gnt_o | p1_gnt_o;

        if (p1_gnt_o) begin
            ram_addr_o  = p1_addr_i;
            ram_wdata_o = p1_wdata_i;
            ram_we_o    = p1_we_i;
            ram_be_o    = p1_be_i;
        end else begin
            ram_addr_o  = p0_addr_i;
            ram_wdata_o = p0_wdata_i;
            ram_we_o    = p0_we_i & p0_gnt_o;
            ram_be_o    = p0_gnt_o ? p0_be_i : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (p0_gnt_o) begin
            state_d = PRIO_P1;
        end else if (p1_gnt_o) begin
            state_d = PRIO_P0;
        end

        own_valid_d = ram_en_o;
        own_port_d  = p1_gnt_o;
        own_read_d  = ~ram_we_o;

        cnt_d = cnt_q;
        if (p0_req_i && p1_req_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Read data passes straight through in the response cycle and is then held.
    always_comb begin
        p0_rvalid_o = own_valid_q & ~own_port_q;
        p1_rvalid_o = own_valid_q & own_port_q;
        p0_rdata_o  = (p0_rvalid_o && own_read_q) ? ram_rdata_i : rdata0_q;
        p1_rdata_o  = (p1_rvalid_o && own_read_q) ? ram_rdata_i : rdata1_q;
        rdata0_d    = p0_rdata_o;
        rdata1_d    = p1_rdata_o;
    end

    assign conflict_cnt_o = cnt_q;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= PRIO_P0;
            own_valid_q <= 1'b0;
            own_port_q  <= 1'b0;
            own_read_q  <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            own_valid_q <= own_valid_d;
            own_port_q  <= own_port_d;
            own_read_q  <= own_read_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter: vector table plus hand sequences for
// contention, mid-operation reset and counter saturation, against a small RAM model.
module tb_sp_ram_arbiter;

    logic        clk;
    logic        rstn;
    logic        p0_req, p1_req, p0_gnt, p1_gnt, p0_we, p1_we;
    logic [14:0] p0_addr, p1_addr;
    logic [3:0]  p0_be, p1_be;
    logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
    logic        p0_rvalid, p1_rvalid;
    logic        ram_en, ram_we;
    logic [14:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    sp_ram_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) dut (
        .clk(clk), .rstn_i(rstn),
        .p0_req_i(p0_req), .p0_gnt_o(p0_gnt), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
        .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_gnt_o(p1_gnt), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
        .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we),
        .ram_be_o(ram_be), .ram_rdata_i(ram_rdata), .conflict_cnt_o(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16-word RAM model, read data one cycle after enable
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[5:2]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r0, r1, we0, we1;
        logic [14:0] a0, a1;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1;
        logic        g0, g1, en, rwe;
        logic [14:0] raddr;
        logic [3:0]  rbe;
        logic [31:0] rwd;
        logic        v0, v1;
        logic [31:0] d0, d1;
        logic [15:0] cnt;
    } vec_t;

    localparam logic        Y   = 1'b1;
    localparam logic        N   = 1'b0;
    localparam logic [31:0] Z   = 32'h0;
    localparam logic [31:0] DB  = 32'hDEADBEEF;
    localparam logic [31:0] M0  = 32'h10000000;
    localparam logic [31:0] M1  = 32'h10000001;
    localparam logic [31:0] M2W = 32'h10005678;
    localparam logic [31:0] WD  = 32'h12345678;

    vec_t vecs [14];

    task automatic drive(input logic r0, input logic r1, input logic [14:0] a0, input logic [14:0] a1);
        p0_req = r0; p1_req = r1; p0_addr = a0; p1_addr = a1;
        p0_we = 1'b0; p1_we = 1'b0; p0_be = 4'hF; p1_be = 4'hF; p0_wdata = Z; p1_wdata = Z;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h10000000 + i;
        mem[4] = DB;
        ram_rdata = Z;

        //           r0 r1 we0 we1 a0      a1      be0   be1   wd0 wd1 | g0 g1 en rwe raddr  rbe   rwd v0 v1 d0   d1   cnt
        vecs[0]  = '{Y, N, N, N, 15'h10, 15'h0, 4'hF, 4'h0, Z, Z,  Y, N, Y, N, 15'h10, 4'hF, Z, N, N, Z,   Z,   16'd0};
        vecs[1]  = '{N, N, N, N, 15'h0,  15'h0, 4'h0, 4'h0, Z, Z,  N, N, N, N, 15'h0,  4'h0, Z, Y, N, DB,  Z,   16'd0};
        vecs[2]  = '{N, N, N, N, 15'h0,  15'h0, 4'h0, 4'h0, Z, Z,  N, N, N, N, 15'h0,  4'h0, Z, N, N, DB,  Z,   16'd0};
        vecs[3]  = '{Y, Y, N, N, 15'h0,  15'h4, 4'hF, 4'hF, Z, Z,  N, Y, Y, N, 15'h4,  4'hF, Z, N, N, DB,  Z,   16'd0};
        vecs[4]  = '{Y, N, N, N, 15'h0,  15'h0, 4'hF, 4'h0, Z, Z,  Y, N, Y, N, 15'h0,  4'hF, Z, N, Y, DB,  M1,  16'd1};
        vecs[5]  = '{N, Y, N, Y, 15'h0,  15'h8, 4'h0, 4'h3, Z, WD, N, Y, Y, Y, 15'h8,  4'h3, WD, Y, N, M0, M1,  16'd1};
        vecs[6]  = '{Y, Y, N, N, 15'h10, 15'h8, 4'hF, 4'hF, Z, Z,  Y, N, Y, N, 15'h10, 4'hF, Z, N, Y, M0,  M1,  16'd1};
        vecs[7]  = '{N, Y, N, N, 15'h0,  15'h8, 4'h0, 4'hF, Z, Z,  N, Y, Y, N, 15'h8,  4'hF, Z, Y, N, DB,  M1,  16'd2};
        vecs[8]  = '{N, N, Y, N, 15'h0,  15'h0, 4'hF, 4'h0, Z, Z,  N, N, N, N, 15'h0,  4'h0, Z, N, Y, DB,  M2W, 16'd2};
        vecs[9]  = '{Y, N, N, N, 15'h0,  15'h0, 4'hF, 4'h0, Z, Z,  Y, N, Y, N, 15'h0,  4'hF, Z, N, N, DB,  M2W, 16'd2};
        vecs[10] = '{Y, N, N, N, 15'h4,  15'h0, 4'hF, 4'h0, Z, Z,  Y, N, Y, N, 15'h4,  4'hF, Z, Y, N, M0,  M2W, 16'd2};
        vecs[11] = '{Y, N, N, N, 15'h8,  15'h0, 4'hF, 4'h0, Z, Z,  Y, N, Y, N, 15'h8,  4'hF, Z, Y, N, M1,  M2W, 16'd2};
        vecs[12] = '{N, N, N, N, 15'h0,  15'h0, 4'h0, 4'h0, Z, Z,  N, N, N, N, 15'h0,  4'h0, Z, Y, N, M2W, M2W, 16'd2};
        vecs[13] = '{N, N, N, N, 15'h0,  15'h0, 4'h0, 4'h0, Z, Z,  N, N, N, N, 15'h0,  4'h0, Z, N, N, M2W, M2W, 16'd2};

        rstn = 1'b0;
        drive(N, N, 15'h0, 15'h0);
        #2;
        check("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
        check("rst_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
        check("rst_p0_rdata", p0_rdata, Z);
        check("rst_p1_rdata", p1_rdata, Z);
        check("rst_cnt", {16'b0, conflict_cnt}, 32'd0);
        p0_req = 1'b1;
        #1;
        check("rst_p0_gnt_follows", {31'b0, p0_gnt}, 32'd1);
        check("rst_ram_en_follows", {31'b0, ram_en}, 32'd1);
        drive(N, Y, 15'h0, 15'h0);
        #1;
        check("rst_p1_gnt_follows", {31'b0, p1_gnt}, 32'd1);
        drive(N, N, 15'h0, 15'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            p0_req = vecs[i].r0;  p1_req = vecs[i].r1;
            p0_we = vecs[i].we0;  p1_we = vecs[i].we1;
            p0_addr = vecs[i].a0; p1_addr = vecs[i].a1;
            p0_be = vecs[i].be0;  p1_be = vecs[i].be1;
            p0_wdata = vecs[i].wd0; p1_wdata = vecs[i].wd1;
            #1;
            check($sformatf("v%0d_p0_gnt", i), {31'b0, p0_gnt}, {31'b0, vecs[i].g0});
            check($sformatf("v%0d_p1_gnt", i), {31'b0, p1_gnt}, {31'b0, vecs[i].g1});
            check($sformatf("v%0d_ram_en", i), {31'b0, ram_en}, {31'b0, vecs[i].en});
            check($sformatf("v%0d_ram_we", i), {31'b0, ram_we}, {31'b0, vecs[i].rwe});
            check($sformatf("v%0d_ram_be", i), {28'b0, ram_be}, {28'b0, vecs[i].rbe});
            if (vecs[i].en) begin
                check($sformatf("v%0d_ram_addr", i), {17'b0, ram_addr}, {17'b0, vecs[i].raddr});
                check($sformatf("v%0d_ram_wdata", i), ram_wdata, vecs[i].rwd);
            end
            check($sformatf("v%0d_p0_rvalid", i), {31'b0, p0_rvalid}, {31'b0, vecs[i].v0});
            check($sformatf("v%0d_p1_rvalid", i), {31'b0, p1_rvalid}, {31'b0, vecs[i].v1});
            check($sformatf("v%0d_p0_rdata", i), p0_rdata, vecs[i].d0);
            check($sformatf("v%0d_p1_rdata", i), p1_rdata, vecs[i].d1);
            check($sformatf("v%0d_cnt", i), {16'b0, conflict_cnt}, {16'b0, vecs[i].cnt});
        end

        // Contention from a fresh reset: strict alternation starting with port 0
        @(negedge clk);
        drive(N, N, 15'h0, 15'h0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(Y, Y, 15'h0, 15'h4);
            #1;
            check($sformatf("cont%0d_p0_gnt", k), {31'b0, p0_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont%0d_p1_gnt", k), {31'b0, p1_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        drive(N, N, 15'h0, 15'h0);
        #1;
        check("cont_cnt", {16'b0, conflict_cnt}, 32'd4);
        check("cont_last_p1_rvalid", {31'b0, p1_rvalid}, 32'd1);
        check("cont_p1_rdata", p1_rdata, M1);

        // Reset asserted the cycle after a port-1 read grant drops the response
        @(negedge clk);
        drive(N, Y, 15'h0, 15'h4);
        #1;
        check("midrst_p1_gnt", {31'b0, p1_gnt}, 32'd1);
        @(negedge clk);
        drive(N, N, 15'h0, 15'h0);
        rstn = 1'b0;
        #1;
        check("midrst_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
        check("midrst_p0_rdata", p0_rdata, Z);
        check("midrst_p1_rdata", p1_rdata, Z);
        check("midrst_cnt", {16'b0, conflict_cnt}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("postrst_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
        drive(Y, Y, 15'h0, 15'h4);
        #1;
        check("postrst_prio_p0", {31'b0, p0_gnt}, 32'd1);

        // Saturation of the conflict counter
        repeat (65534) @(negedge clk);
        check("sat_fffe", {16'b0, conflict_cnt}, 32'h0000FFFE);
        @(negedge clk);
        check("sat_ffff", {16'b0, conflict_cnt}, 32'h0000FFFF);
        repeat (4466) @(negedge clk);
        check("sat_hold", {16'b0, conflict_cnt}, 32'h0000FFFF);
        drive(N, N, 15'h0, 15'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
